// File: rtl/cic_pkg.sv
// Shared constants, default droop-compensation coefficients and FSM states
// for the CIC compensation FIR.
package cic_pkg;

    localparam int unsigned COEF_W    = 16;
    localparam int unsigned FRAC      = COEF_W - 2;
    localparam int unsigned NTAPS_DEF = 7;

    typedef logic signed [COEF_W-1:0] coef_t;

    // Symmetric Q2.14 table, taps sum to 16384 so DC gain is exactly 1
    localparam coef_t COEF_DEF [NTAPS_DEF] = '{
        coef_t'(-256), coef_t'(1024), coef_t'(-2048), coef_t'(18944),
        coef_t'(-2048), coef_t'(1024), coef_t'(-256)
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DONE
    } state_t;

endpackage

// File: rtl/cic_comp_rom.sv
// Combinational coefficient lookup: tap index -> COEF[index].
// Replacing the table here leaves the MAC datapath untouched.
module cic_comp_rom
    import cic_pkg::*;
#(
    parameter int unsigned NTAPS = NTAPS_DEF,
    parameter int unsigned Wc    = COEF_W,
    parameter int unsigned AW    = $clog2(NTAPS)
) (
    input  logic [AW-1:0]        addr,
    output logic signed [Wc-1:0] coef
);

    always_comb begin
        coef = '0;
        for (int unsigned i = 0; i < NTAPS_DEF; i++) begin
            if (i == 32'(addr)) coef = Wc'(COEF_DEF[i]);
        end
    end

endmodule

// File: rtl/cic_comp_fir.sv
// Time-multiplexed symmetric FIR (one multiplier, one tap per clock) feeding the CIC.
// Define CIC_COMP_SAT_EN to clamp the scaled result instead of wrapping it.
module cic_comp_fir
    import cic_pkg::*;
#(
    parameter int unsigned Win   = 16,
    parameter int unsigned Wc    = COEF_W,
    parameter int unsigned NTAPS = NTAPS_DEF,
    parameter int unsigned Wout  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   val_in,
    input  logic signed [Win-1:0]  i_data,
    output logic                   ready,
    output logic                   err,
    output logic                   val_out,
    output logic signed [Wout-1:0] o_data
);

    localparam int unsigned FRAC_S = Wc - 2;
    localparam int unsigned WP     = Win + Wc;
    localparam int unsigned WACC   = WP + $clog2(NTAPS);
    localparam int unsigned AW     = $clog2(NTAPS);

    logic signed [Win-1:0]  x [NTAPS];
    logic signed [WACC-1:0] acc;
    logic [AW-1:0]          cnt;
    state_t                 state;
    logic signed [Wc-1:0]   coef;
    logic signed [Win-1:0]  x_sel;
    logic signed [WP-1:0]   prod;
    logic signed [Wout-1:0] scaled;

    cic_comp_rom #(
        .NTAPS (NTAPS),
        .Wc    (Wc),
        .AW    (AW)
    ) u_rom (
        .addr (cnt),
        .coef (coef)
    );

    always_comb begin
        x_sel = x[cnt];
        prod  = x_sel * coef;
    end

`ifdef CIC_COMP_SAT_EN
    localparam logic signed [WACC-1:0] OMAX = {{(WACC-Wout+1){1'b0}}, {(Wout-1){1'b1}}};
    localparam logic signed [WACC-1:0] OMIN = {{(WACC-Wout+1){1'b1}}, {(Wout-1){1'b0}}};
    logic signed [WACC-1:0] shifted;

    always_comb begin
        shifted = acc >>> FRAC_S;
        if (shifted > OMAX)      scaled = {1'b0, {(Wout-1){1'b1}}};
        else if (shifted < OMIN) scaled = {1'b1, {(Wout-1){1'b0}}};
        else                     scaled = shifted[Wout-1:0];
    end
`else
    always_comb begin
        scaled = Wout'(acc >>> FRAC_S);
    end
`endif

    // ready mirrors (state == S_IDLE); kept as a register so the port is glitch-free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            ready   <= 1'b1;
            err     <= 1'b0;
            val_out <= 1'b0;
            o_data  <= '0;
            acc     <= '0;
            cnt     <= '0;
            for (int unsigned k = 0; k < NTAPS; k++) x[k] <= '0;
        end else begin
            val_out <= 1'b0;
            if (val_in && !ready) err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (val_in && ready) begin
                        x[0] <= i_data;
                        for (int unsigned k = 1; k < NTAPS; k++) x[k] <= x[k-1];
                        acc   <= '0;
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + WACC'(prod);
                    if (cnt == AW'(NTAPS - 1)) state <= S_DONE;
                    else                       cnt   <= cnt + AW'(1);
                end
                S_DONE: begin
                    o_data  <= scaled;
                    val_out <= 1'b1;
                    ready   <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Randomized and directed checks of cic_comp_fir against a direct-form convolution model.
// Expectations follow CIC_COMP_SAT_EN when it is defined for the build.
module tb_cic_comp_fir;

    localparam int NT = 7;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               val_in = 1'b0;
    logic signed [15:0] i_data = '0;
    logic               ready, err, val_out;
    logic signed [15:0] o_data;

    int errs   = 0;
    int checks = 0;

    int coef_tab [NT] = '{-256, 1024, -2048, 18944, -2048, 1024, -256};
    int hist [NT];
    int imp_exp [8] = '{-16, 62, -125, 1156, -125, 62, -16, 0};

    cic_comp_fir #(
        .Win   (16),
        .Wc    (16),
        .NTAPS (7),
        .Wout  (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .val_in  (val_in),
        .i_data  (i_data),
        .ready   (ready),
        .err     (err),
        .val_out (val_out),
        .o_data  (o_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int reduce(input longint s);
`ifdef CIC_COMP_SAT_EN
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        return int'(s);
`else
        longint m;
        m = s & 64'hFFFF;
        if (m >= 32768) m = m - 65536;
        return int'(m);
`endif
    endfunction

    // Model: push accepted sample, convolve history with the table, floor-divide by 2^14
    function automatic int model_push(input int v);
        longint s = 0;
        for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = v;
        for (int k = 0; k < NT; k++) s += longint'(hist[k]) * longint'(coef_tab[k]);
        return reduce(s >>> 14);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NT; k++) hist[k] = 0;
    endfunction

    // One sample driven at cycle 0; optional overrun strobe at cycle ovr (0 = none)
    task automatic run_sample(input int v, input int ovr, input int ovr_val, output int got);
        int exp, lat, vcnt, rdy_bad;
        bit found;
        lat = -1; vcnt = 0; rdy_bad = 0; found = 0; got = 0;
        check("ready_before", int'(ready), 1);
        val_in = 1'b1;
        i_data = 16'(v);
        exp = model_push(v);
        @(posedge clk); #1;
        val_in = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (val_out) begin
                vcnt++;
                if (!found) begin found = 1; lat = n; got = int'(o_data); end
            end
            if (n < NT + 2 && ready) rdy_bad++;
            if (n == ovr) begin val_in = 1'b1; i_data = 16'(ovr_val); end
            @(posedge clk); #1;
            val_in = 1'b0;
        end
        check("latency", lat, NT + 2);
        check("val_out_count", vcnt, 1);
        check("ready_low", rdy_bad, 0);
        check("o_data_model", got, exp);
    endtask

    initial begin
        int got, v, exp1, exp2, lat2, o1, rb, vo;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(ready), 1);
        check("rst_err", int'(err), 0);
        check("rst_val_out", int'(val_out), 0);
        check("rst_o_data", int'(o_data), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Impulse response
        for (int i = 0; i < 8; i++) begin
            run_sample(i == 0 ? 1000 : 0, 0, 0, got);
            check($sformatf("impulse_%0d", i), got, imp_exp[i]);
        end

        // DC gain of one
        for (int i = 0; i < 8; i++) run_sample(1000, 0, 0, got);
        check("dc_settle", got, 1000);

        // Nyquist, last input positive
        for (int i = 0; i < 9; i++) run_sample((i % 2 == 0) ? 32000 : -32000, 0, 0, got);
`ifdef CIC_COMP_SAT_EN
        check("nyquist", got, -32768);
`else
        check("nyquist", got, 15536);
`endif

        // Randomized samples
        for (int i = 0; i < 30; i++) begin
            v = int'($urandom_range(0, 65535)) - 32768;
            run_sample(v, 0, 0, got);
        end
        check("err_clean", int'(err), 0);

        // Back-to-back: second strobe in the val_out cycle
        val_in = 1'b1; i_data = 16'sd1200;
        exp1 = model_push(1200);
        @(posedge clk); #1;
        val_in = 1'b0;
        rb = 0; vo = 0;
        for (int n = 1; n < NT + 2; n++) begin
            if (ready) rb++;
            if (val_out) vo++;
            @(posedge clk); #1;
        end
        check("b2b_ready_low", rb, 0);
        check("b2b_no_early_val", vo, 0);
        check("b2b_val_out_c9", int'(val_out), 1);
        check("b2b_ready_c9", int'(ready), 1);
        o1 = int'(o_data);
        check("b2b_first", o1, exp1);
        val_in = 1'b1; i_data = -16'sd700;
        exp2 = model_push(-700);
        @(posedge clk); #1;
        val_in = 1'b0;
        lat2 = -1;
        for (int n = 1; n <= 20; n++) begin
            if (val_out && lat2 < 0) begin lat2 = n; o1 = int'(o_data); end
            @(posedge clk); #1;
        end
        check("b2b_latency2", lat2, NT + 2);
        check("b2b_second", o1, exp2);

        // Overrun at cycle 3: dropped, err sticky
        run_sample(5000, 3, 12345, got);
        check("overrun_err", int'(err), 1);
        run_sample(-3000, 0, 0, got);
        check("err_sticky", int'(err), 1);

        // Reset at cycle 4 of a MAC aborts the sample
        val_in = 1'b1; i_data = 16'sd9000;
        @(posedge clk); #1;
        val_in = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("mid_rst_ready", int'(ready), 1);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_val_out", int'(val_out), 0);
        check("mid_rst_o_data", int'(o_data), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        vo = 0;
        for (int n = 0; n < 15; n++) begin
            if (val_out) vo++;
            @(posedge clk); #1;
        end
        check("mid_rst_no_out", vo, 0);
        for (int i = 0; i < 8; i++) begin
            run_sample(i == 0 ? 1000 : 0, 0, 0, got);
            check($sformatf("impulse2_%0d", i), got, imp_exp[i]);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
